// File: rtl/alu_decode_stage.sv
// Decode stage: MIPS {op,funct} -> ALU control, mem and reserved flags, buffered in a DEPTH-entry FIFO.
// Latency 1 cycle; in_ready = !full. Optional mult/div decode enabled by MULDIV_EN.
module alu_decode_stage #(
  parameter int ALUCTRL_W = 5,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_op,
  input  logic [5:0]           in_funct,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 is_mem,
  output logic                 ri,
  output logic [31:0]          out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic        mem;
    logic        ri;
    logic [31:0] pc;
  } entry_t;

  entry_t        dec;
  entry_t        head;
  entry_t        last;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  always_comb begin
    dec      = '0;
    dec.pc   = in_pc;
    case (in_op)
      6'b000000: begin
        case (in_funct)
          6'b100100: dec.ctrl = 5'b00111;
          6'b100101: dec.ctrl = 5'b00001;
          6'b100110: dec.ctrl = 5'b00010;
          6'b100111: dec.ctrl = 5'b00011;
          6'b000000: dec.ctrl = 5'b01000;
          6'b000010: dec.ctrl = 5'b01001;
          6'b000011: dec.ctrl = 5'b01010;
          6'b000100: dec.ctrl = 5'b01011;
          6'b000110: dec.ctrl = 5'b01100;
          6'b000111: dec.ctrl = 5'b01101;
          6'b100000: dec.ctrl = 5'b10001;
          6'b100001: dec.ctrl = 5'b10010;
          6'b100010: dec.ctrl = 5'b10011;
          6'b100011: dec.ctrl = 5'b10100;
          6'b101010: dec.ctrl = 5'b10101;
          6'b101011: dec.ctrl = 5'b10110;
          6'b001000, 6'b001001, 6'b001100, 6'b001101: dec.ctrl = 5'b00000;
`ifdef MULDIV_EN
          6'b011000: dec.ctrl = 5'b11000;
          6'b011001: dec.ctrl = 5'b11001;
          6'b011010: dec.ctrl = 5'b11010;
          6'b011011: dec.ctrl = 5'b11011;
          6'b010000: dec.ctrl = 5'b11100;
          6'b010010: dec.ctrl = 5'b11101;
          6'b010001: dec.ctrl = 5'b11110;
          6'b010011: dec.ctrl = 5'b11111;
`endif
          default:   dec.ri   = 1'b1;
        endcase
      end
      6'b001100: dec.ctrl = 5'b00111;
      6'b001110: dec.ctrl = 5'b00010;
      6'b001111: dec.ctrl = 5'b00100;
      6'b001101: dec.ctrl = 5'b00001;
      6'b001000: dec.ctrl = 5'b10001;
      6'b001001: dec.ctrl = 5'b10010;
      6'b001010: dec.ctrl = 5'b10101;
      6'b001011: dec.ctrl = 5'b10110;
      6'b100000, 6'b100100, 6'b100001, 6'b100101,
      6'b100011, 6'b101000, 6'b101001, 6'b101011: begin
        dec.ctrl = 5'b10000;
        dec.mem  = 1'b1;
      end
      6'b000001, 6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111: dec.ctrl = 5'b00000;
      default: dec.ri = 1'b1;
    endcase
  end

  assign in_ready  = (count != (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Storage needs no reset: while empty the outputs come from 'last'.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last   <= mem_q[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = out_valid ? mem_q[rd_ptr] : last;
  assign alucontrol = ALUCTRL_W'(head.ctrl);
  assign is_mem     = head.mem;
  assign ri         = head.ri;
  assign out_pc     = head.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized bench for alu_decode_stage against a queue-based model and decode table.
module tb_alu_decode_stage;

  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_op;
  logic [5:0]   in_funct;
  logic [31:0]  in_pc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alucontrol;
  logic         is_mem;
  logic         ri;
  logic [31:0]  out_pc;

  alu_decode_stage #(.ALUCTRL_W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct(in_funct), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .alucontrol(alucontrol), .is_mem(is_mem), .ri(ri), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic        mem;
    logic        ri;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decode from the MIPS mnemonic tables.
  function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc);
    exp_t e;
    int   r_code[64];
    int   i_code[64];
    e.pc = pc; e.mem = 0; e.ri = 0; e.ctrl = 0;
    for (int k = 0; k < 64; k++) begin r_code[k] = -1; i_code[k] = -1; end
    r_code[36] = 7;  r_code[37] = 1;  r_code[38] = 2;  r_code[39] = 3;
    r_code[0]  = 8;  r_code[2]  = 9;  r_code[3]  = 10; r_code[4]  = 11;
    r_code[6]  = 12; r_code[7]  = 13;
    r_code[32] = 17; r_code[33] = 18; r_code[34] = 19; r_code[35] = 20;
    r_code[42] = 21; r_code[43] = 22;
    r_code[8]  = 0;  r_code[9]  = 0;  r_code[12] = 0;  r_code[13] = 0;
`ifdef MULDIV_EN
    r_code[24] = 24; r_code[25] = 25; r_code[26] = 26; r_code[27] = 27;
    r_code[16] = 28; r_code[18] = 29; r_code[17] = 30; r_code[19] = 31;
`endif
    i_code[12] = 7;  i_code[14] = 2;  i_code[15] = 4;  i_code[13] = 1;
    i_code[8]  = 17; i_code[9]  = 18; i_code[10] = 21; i_code[11] = 22;
    for (int k = 1; k <= 7; k++) i_code[k] = 0;
    if (op == 0) begin
      if (r_code[fn] < 0) e.ri = 1; else e.ctrl = 5'(r_code[fn]);
    end else if (op inside {6'd32, 6'd36, 6'd33, 6'd37, 6'd35, 6'd40, 6'd41, 6'd43}) begin
      e.ctrl = 5'd16; e.mem = 1;
    end else if (i_code[op] >= 0) begin
      e.ctrl = 5'(i_code[op]);
    end else begin
      e.ri = 1;
    end
    return e;
  endfunction

  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    if (q.size() > 0) begin
      chk("alucontrol", 64'(alucontrol), 64'(q[0].ctrl));
      chk("is_mem", 64'(is_mem), 64'(q[0].mem));
      chk("ri", 64'(ri), 64'(q[0].ri));
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
    end
  endtask

  // Apply inputs for one cycle, advance the model across the edge, then compare.
  task automatic cycle(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] pc, input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid = v; in_op = op; in_funct = fn; in_pc = pc; out_ready = ordy; flush = fl;
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = ordy && (q.size() > 0) && !fl;
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(ref_decode(op, fn, pc));
    end
    compare();
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_op = 0; in_funct = 0; in_pc = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst alucontrol", 64'(alucontrol), 64'd0);
    chk("rst is_mem", 64'(is_mem), 64'd0);
    chk("rst ri", 64'(ri), 64'd0);
    chk("rst out_pc", 64'(out_pc), 64'd0);
    rst = 0;

    // AND then LW then reserved op, streamed with out_ready=1
    cycle(1, 6'h00, 6'b100100, 32'h0040_0000, 1, 0);
    chk("and valid", 64'(out_valid), 64'd1);
    chk("and ctrl", 64'(alucontrol), 64'h07);
    chk("and pc", 64'(out_pc), 64'h0040_0000);
    cycle(1, 6'b100011, 6'h15, 32'h0040_0004, 1, 0);
    chk("lw ctrl", 64'(alucontrol), 64'h10);
    chk("lw is_mem", 64'(is_mem), 64'd1);
    cycle(1, 6'b111111, 6'h00, 32'h0040_0008, 1, 0);
    chk("rsv ctrl", 64'(alucontrol), 64'h00);
    chk("rsv ri", 64'(ri), 64'd1);
    cycle(0, 0, 0, 0, 1, 0);
    chk("drained", 64'(out_valid), 64'd0);

    // Fill to full, third push must be dropped, then drain
    cycle(1, 6'b001111, 0, 32'h100, 0, 0);
    cycle(1, 6'b001000, 0, 32'h104, 0, 0);
    chk("full in_ready", 64'(in_ready), 64'd0);
    cycle(1, 6'b001101, 0, 32'h108, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("after pop in_ready", 64'(in_ready), 64'd1);
    chk("2nd head ctrl", 64'(alucontrol), 64'h11);
    chk("2nd head pc", 64'(out_pc), 64'h104);

    // Count=1 push+pop across pointer wrap
    for (int i = 0; i < 8; i++) cycle(1, 6'h00, 6'b100000 + 6'(i % 4), 32'h200 + 32'(4*i), 1, 0);
    chk("stream pc", 64'(out_pc), 64'h21c);

    // Two buffered, flush with in_valid
    cycle(1, 6'h00, 6'b100110, 32'h300, 0, 0);
    cycle(1, 6'h00, 6'b100111, 32'h304, 0, 1);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);

    // Multiply funct, upper bits of the wide control word
    cycle(1, 6'h00, 6'b011000, 32'h400, 0, 0);
`ifdef MULDIV_EN
    chk("mult ctrl", 64'(alucontrol), 64'h18);
    chk("mult ri", 64'(ri), 64'd0);
`else
    chk("mult ctrl", 64'(alucontrol), 64'h00);
    chk("mult ri", 64'(ri), 64'd1);
`endif
    cycle(0, 0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      cycle(1'($urandom), op, 6'($urandom), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-operation
    cycle(1, 6'b101011, 0, 32'h500, 0, 0);
    cycle(1, 6'b101000, 0, 32'h504, 0, 0);
    #1 rst = 1;
    #1;
    q.delete();
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst alucontrol", 64'(alucontrol), 64'd0);
    chk("arst out_pc", 64'(out_pc), 64'd0);
    #1 rst = 0;
    cycle(1, 6'b001110, 0, 32'h600, 0, 0);
    chk("post-rst xori", 64'(alucontrol), 64'h02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered, parametrised ALU decode stage for the MIPS integer pipeline. It sits between fetch and execute. It accepts {op, funct, pc} through a valid/ready handshake and decodes each instruction into an ALU control word plus mem-access and reserved-instruction flags. Results are buffered in a DEPTH-entry FIFO so execute-side stalls do not lose instructions.

## Interface

Parameters:
- ALUCTRL_W, default 5: width of alucontrol; must be ≥5; bits above [4:0] are always 0.
- DEPTH, default 2: buffer entries; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; equals !full.
- in_op  in  6  instruction[31:26].
- in_funct  in  6  instruction[5:0].
- in_pc  in  32  instruction PC; passed through unchanged.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  downstream accepts the head.
- alucontrol  out  ALUCTRL_W  decoded control word of the head entry.
- is_mem  out  1  head is a load/store.
- ri  out  1  head is a reserved instruction.
- out_pc  out  32  PC of the head entry.

## Operation

- Decode is combinational on in_* and is written into the FIFO on push (in_valid & in_ready).
- op=000000, decoded by funct:
  - and 00111, or 00001, xor 00010, nor 00011.
  - sll 01000, srl 01001, sra 01010, sllv 01011, srlv 01100, srav 01101.
  - add 10001, addu 10010, sub 10011, subu 10100, slt 10101, sltu 10110.
  - jr, jalr, syscall, break give 00000 with ri=0.
- Immediate ops:
  - andi 00111, xori 00010, lui 00100, ori 00001.
  - addi 10001, addiu 10010, slti 10101, sltiu 10110.
- Mem ops (LB, LBU, LH, LHU, LW, SB, SH, SW) give 10000 with is_mem=1.
- Branch/jump ops (000001, 000010–000111) give 00000 with ri=0.
- Any other op, or any other funct under op=000000, gives alucontrol 00000 and ri=1.
- FIFO behaviour:
  - Push writes at the write pointer; pop (out_valid & out_ready) advances the read pointer.
  - Both pointers wrap modulo DEPTH; a count register holds 0..DEPTH.
- Output fields always reflect the entry at the read pointer. When empty they hold the last popped entry, or 0 after reset or flush; they are don't-care while out_valid=0.
- flush=1 clears count and both pointers at the next edge. A push or pop in the same cycle is ignored, and flush wins.

## Timing

- Reset values: in_ready=1, out_valid=0, alucontrol=0, is_mem=0, ri=0, out_pc=0, count=0, pointers 0.
- Latency: a push into an empty FIFO gives out_valid=1 the following cycle; there is no combinational in→out path.
- in_ready depends only on count and is never combinationally dependent on out_ready. When full, a pop frees a slot only from the next cycle.
- Simultaneous push and pop with 0<count<DEPTH leaves count unchanged and moves both pointers.
- Push with in_ready=0 is ignored; upstream holds in_valid and data.
- Pop with out_valid=0 is ignored.
- Asserting rst mid-operation clears all state immediately; buffered instructions are lost.

## Configuration

- MULDIV_EN defined:
  - Under op=000000: mult 11000, multu 11001, div 11010, divu 11011, mfhi 11100, mflo 11101, mthi 11110, mtlo 11111, all with ri=0.
- MULDIV_EN undefined:
  - Those eight functs decode as reserved: alucontrol 00000, ri=1.

## Test plan

- Reset, then push op=000000 funct=100100 pc=0x00400000 with out_ready=1 → next cycle: out_valid=1, alucontrol=00111, ri=0, is_mem=0, out_pc=0x00400000.
- Push LW (op=100011), then op=111111 → heads in order: 10000 with is_mem=1, then 00000 with ri=1.
- DEPTH=2 with out_ready=0: push 2 entries → in_ready=0; a 3rd push is ignored. Raise out_ready → entries drain in order; in_ready=1 one cycle after the first pop.
- Count=1 with simultaneous push and pop held for 8 cycles → out_valid stays 1, in_ready stays 1, entries are delivered in order across pointer wrap.
- With 2 entries buffered, assert flush together with in_valid → next cycle: out_valid=0, in_ready=1, and the pushed entry is discarded.
- op=000000 funct=011000 → alucontrol 11000 with ri=0 when MULDIV_EN is defined; 00000 with ri=1 when undefined. With ALUCTRL_W=8, upper 3 bits are 0.
